// File: rtl/fwd_stall_unit.sv
// fwd_stall_unit: forwarding and stall controller for the 5-stage MIPS pipeline.
// Keeps shadow copies of the EX/MEM/WB destinations and their result-ready
// times, applies Tuse/Tnew hazard rules, and tracks the mult/div busy period.
//
// Tnew bookkeeping: the MEM shadow stores the EX tnew already decremented on
// entry, so that stored value is directly the Tnew seen from ID (ALU -> 0,
// load -> 1), and a MEM result is ready to forward when the stored value is 0.
module fwd_stall_unit #(
    parameter int AW      = 5,
    parameter int NSRC    = 2,
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [NSRC*AW-1:0] id_src,
    input  logic [NSRC*2-1:0]  id_tuse,
    input  logic [AW-1:0]      id_dst,
    input  logic               id_wen,
    input  logic [1:0]         id_tnew,
    input  logic               id_md_start,
    input  logic               id_md_div,
    input  logic               id_md_use,
    output logic               stall,
    output logic [NSRC*2-1:0]  fwd_id,
    output logic [NSRC*2-1:0]  fwd_ex,
    output logic               md_busy
);

    localparam int CW = $clog2(DIV_LAT + 1);

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_MEM = 2'b10;
    localparam logic [1:0] SEL_WB  = 2'b01;

    // EX shadow
    logic [NSRC*AW-1:0] ex_src;
    logic [NSRC*2-1:0]  ex_tuse;
    logic [AW-1:0]      ex_dst;
    logic               ex_wen;
    logic [1:0]         ex_tnew;
    // MEM shadow
    logic [AW-1:0]      mem_dst;
    logic               mem_wen;
    logic [1:0]         mem_tnew;
    // WB shadow
    logic [AW-1:0]      wb_dst;
    logic               wb_wen;

    logic [CW-1:0]      md_count;

    logic ex_live, mem_live, wb_live;
    logic data_stall, md_stall, advance;

    // An entry that writes register 0 (or does not write at all) never matches.
    assign ex_live  = ex_wen  && (ex_dst  != '0);
    assign mem_live = mem_wen && (mem_dst != '0);
    assign wb_live  = wb_wen  && (wb_dst  != '0);

    assign md_busy  = (md_count != '0);
    assign md_stall = id_valid && id_md_use && md_busy;
    assign stall    = data_stall || md_stall;
    assign advance  = id_valid && !stall;

    function automatic logic hit(input logic          live,
                                 input logic [AW-1:0] dst,
                                 input logic [AW-1:0] src,
                                 input logic [1:0]    tuse);
        return live && (dst == src) && (tuse != 2'd3);
    endfunction

    // Hazard detection and forwarding selects for the ID and EX operands.
    always_comb begin
        data_stall = 1'b0;
        fwd_id     = '0;
        fwd_ex     = '0;
        for (int k = 0; k < NSRC; k++) begin
            if (id_valid) begin
                if (hit(ex_live, ex_dst, id_src[k*AW +: AW], id_tuse[k*2 +: 2]) &&
                    (ex_tnew > id_tuse[k*2 +: 2]))
                    data_stall = 1'b1;
                if (hit(mem_live, mem_dst, id_src[k*AW +: AW], id_tuse[k*2 +: 2]) &&
                    (mem_tnew > id_tuse[k*2 +: 2]))
                    data_stall = 1'b1;
            end

            if (hit(mem_live, mem_dst, id_src[k*AW +: AW], id_tuse[k*2 +: 2]) &&
                (mem_tnew == 2'd0))
                fwd_id[k*2 +: 2] = SEL_MEM;
            else if (hit(wb_live, wb_dst, id_src[k*AW +: AW], id_tuse[k*2 +: 2]))
                fwd_id[k*2 +: 2] = SEL_WB;
            else
                fwd_id[k*2 +: 2] = SEL_RF;

            if (hit(mem_live, mem_dst, ex_src[k*AW +: AW], ex_tuse[k*2 +: 2]) &&
                (mem_tnew == 2'd0))
                fwd_ex[k*2 +: 2] = SEL_MEM;
            else if (hit(wb_live, wb_dst, ex_src[k*AW +: AW], ex_tuse[k*2 +: 2]))
                fwd_ex[k*2 +: 2] = SEL_WB;
            else
                fwd_ex[k*2 +: 2] = SEL_RF;
        end
    end

    // Shadow pipeline: WB <- MEM, MEM <- EX (tnew counts down), EX <- ID or bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_src   <= '0;
            ex_tuse  <= '1;
            ex_dst   <= '0;
            ex_wen   <= 1'b0;
            ex_tnew  <= 2'd0;
            mem_dst  <= '0;
            mem_wen  <= 1'b0;
            mem_tnew <= 2'd0;
            wb_dst   <= '0;
            wb_wen   <= 1'b0;
        end else begin
            wb_dst   <= mem_dst;
            wb_wen   <= mem_wen;
            mem_dst  <= ex_dst;
            mem_wen  <= ex_wen;
            mem_tnew <= (ex_tnew == 2'd0) ? 2'd0 : ex_tnew - 2'd1;
            if (advance) begin
                ex_src  <= id_src;
                ex_tuse <= id_tuse;
                ex_dst  <= id_dst;
                ex_wen  <= id_wen;
                ex_tnew <= id_tnew;
            end else begin
                // Bubble: unused operands so the EX selects stay at register file.
                ex_src  <= '0;
                ex_tuse <= '1;
                ex_dst  <= '0;
                ex_wen  <= 1'b0;
                ex_tnew <= 2'd0;
            end
        end
    end

    // Mult/div busy down-counter; a start entering EX reloads it over a decrement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            md_count <= '0;
        end else if (advance && id_md_start) begin
            md_count <= id_md_div ? CW'(DIV_LAT) : CW'(MUL_LAT);
        end else if (md_count != '0) begin
            md_count <= md_count - CW'(1);
        end
    end

endmodule

// File: tb/tb_fwd_stall_unit.sv
// Directed bench for fwd_stall_unit: a per-cycle vector table plus hand-written
// sequences for mult/div busy periods and reset during a divide.
module tb_fwd_stall_unit;

    logic       clk;
    logic       rst_n;
    logic       id_valid;
    logic [9:0] id_src;
    logic [3:0] id_tuse;
    logic [4:0] id_dst;
    logic       id_wen;
    logic [1:0] id_tnew;
    logic       id_md_start;
    logic       id_md_div;
    logic       id_md_use;
    logic       stall;
    logic [3:0] fwd_id;
    logic [3:0] fwd_ex;
    logic       md_busy;

    int n_total = 0;
    int n_pass  = 0;

    fwd_stall_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .id_valid   (id_valid),
        .id_src     (id_src),
        .id_tuse    (id_tuse),
        .id_dst     (id_dst),
        .id_wen     (id_wen),
        .id_tnew    (id_tnew),
        .id_md_start(id_md_start),
        .id_md_div  (id_md_div),
        .id_md_use  (id_md_use),
        .stall      (stall),
        .fwd_id     (fwd_id),
        .fwd_ex     (fwd_ex),
        .md_busy    (md_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       valid;
        logic [4:0] s0, s1;
        logic [1:0] u0, u1;
        logic [4:0] dst;
        logic       wen;
        logic [1:0] tnew;
        logic       md_start, md_div, md_use;
        logic       x_stall;
        logic [3:0] x_fid, x_fex;
        logic       x_busy;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic valid, input logic [4:0] s0, input logic [4:0] s1,
                                input logic [1:0] u0, input logic [1:0] u1, input logic [4:0] dst,
                                input logic wen, input logic [1:0] tnew,
                                input logic ms, input logic mdv, input logic mu);
        vec_t v;
        v.valid = valid; v.s0 = s0; v.s1 = s1; v.u0 = u0; v.u1 = u1;
        v.dst = dst; v.wen = wen; v.tnew = tnew;
        v.md_start = ms; v.md_div = mdv; v.md_use = mu;
        v.x_stall = 1'b0; v.x_fid = 4'h0; v.x_fex = 4'h0; v.x_busy = 1'b0;
        return v;
    endfunction

    function automatic vec_t nop();
        return mk(1'b0, 5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    endfunction
    function automatic vec_t alu(input logic [4:0] d, input logic [4:0] rs, input logic [4:0] rt);
        return mk(1'b1, rs, rt, 2'd1, 2'd1, d, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
    endfunction
    function automatic vec_t lw(input logic [4:0] d, input logic [4:0] b);
        return mk(1'b1, b, 5'd0, 2'd1, 2'd3, d, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
    endfunction
    function automatic vec_t sw(input logic [4:0] b, input logic [4:0] rt);
        return mk(1'b1, b, rt, 2'd1, 2'd2, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    endfunction
    function automatic vec_t beq(input logic [4:0] rs, input logic [4:0] rt);
        return mk(1'b1, rs, rt, 2'd0, 2'd0, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    endfunction
    function automatic vec_t mdop(input logic dv);
        return mk(1'b1, 5'd1, 5'd2, 2'd1, 2'd1, 5'd0, 1'b0, 2'd0, 1'b1, dv, 1'b1);
    endfunction
    function automatic vec_t mflo(input logic [4:0] d);
        return mk(1'b1, 5'd0, 5'd0, 2'd3, 2'd3, d, 1'b1, 2'd1, 1'b0, 1'b0, 1'b1);
    endfunction

    function automatic vec_t x(input vec_t v, input logic s, input logic [3:0] fi,
                               input logic [3:0] fe, input logic b);
        vec_t r;
        r = v;
        r.x_stall = s; r.x_fid = fi; r.x_fex = fe; r.x_busy = b;
        return r;
    endfunction

    task automatic drive(input vec_t v);
        id_valid    = v.valid;
        id_src      = {v.s1, v.s0};
        id_tuse     = {v.u1, v.u0};
        id_dst      = v.dst;
        id_wen      = v.wen;
        id_tnew     = v.tnew;
        id_md_start = v.md_start;
        id_md_div   = v.md_div;
        id_md_use   = v.md_use;
    endtask

    task automatic check(input string name, input int idx, input logic [7:0] act,
                         input logic [7:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s[%0d]: got %0h, expected %0h", name, idx, act, exp);
    endtask

    task automatic check_outs(input string tag, input int idx, input logic s,
                              input logic [3:0] fi, input logic [3:0] fe, input logic b);
        check({tag, ".stall"},   idx, 8'(stall),   8'(s));
        check({tag, ".fwd_id"},  idx, 8'(fwd_id),  8'(fi));
        check({tag, ".fwd_ex"},  idx, 8'(fwd_ex),  8'(fe));
        check({tag, ".md_busy"}, idx, 8'(md_busy), 8'(b));
    endtask

    // Drives a mult/div consumer each cycle and returns how many cycles md_busy was high.
    task automatic count_busy(input string tag, output int busy_cycles);
        int stall_bad;
        busy_cycles = 0;
        stall_bad   = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            drive(mflo(5'd3));
            #1;
            if (stall !== md_busy) stall_bad++;
            if (md_busy !== 1'b1) break;
            busy_cycles++;
        end
        check({tag, ".stall_tracks_busy"}, 0, 8'(stall_bad), 8'd0);
    endtask

    initial begin
        int busy;

        // ALU -> ALU -> ALU forwarding
        tbl.push_back(x(nop(),               1'b0, 4'h0, 4'h0, 1'b0));
        tbl.push_back(x(alu(5'd3, 5'd1, 5'd2), 1'b0, 4'h0, 4'h0, 1'b0));
        tbl.push_back(x(alu(5'd7, 5'd3, 5'd2), 1'b0, 4'h0, 4'h0, 1'b0));
        tbl.push_back(x(alu(5'd8, 5'd3, 5'd2), 1'b0, 4'b0010, 4'b0010, 1'b0));
        tbl.push_back(x(nop(),               1'b0, 4'h0, 4'b0001, 1'b0));
        tbl.push_back(x(nop(),               1'b0, 4'h0, 4'h0, 1'b0));
        tbl.push_back(x(nop(),               1'b0, 4'h0, 4'h0, 1'b0));
        // load-use: one stall, then WB forward into EX
        tbl.push_back(x(lw(5'd5, 5'd1),      1'b0, 4'h0, 4'h0, 1'b0));
        tbl.push_back(x(alu(5'd9, 5'd5, 5'd2), 1'b1, 4'h0, 4'h0, 1'b0));
        tbl.push_back(x(alu(5'd9, 5'd5, 5'd2), 1'b0, 4'h0, 4'h0, 1'b0));
        tbl.push_back(x(nop(),               1'b0, 4'h0, 4'b0001, 1'b0));
        tbl.push_back(x(nop(),               1'b0, 4'h0, 4'h0, 1'b0));
        tbl.push_back(x(nop(),               1'b0, 4'h0, 4'h0, 1'b0));
        // branch after ALU: one stall, then MEM forward into ID
        tbl.push_back(x(alu(5'd4, 5'd1, 5'd2), 1'b0, 4'h0, 4'h0, 1'b0));
        tbl.push_back(x(beq(5'd4, 5'd2),     1'b1, 4'h0, 4'h0, 1'b0));
        tbl.push_back(x(beq(5'd4, 5'd2),     1'b0, 4'b0010, 4'h0, 1'b0));
        tbl.push_back(x(nop(),               1'b0, 4'h0, 4'b0001, 1'b0));
        // branch after load: two stalls, then WB forward into ID
        tbl.push_back(x(lw(5'd4, 5'd1),      1'b0, 4'h0, 4'h0, 1'b0));
        tbl.push_back(x(beq(5'd4, 5'd2),     1'b1, 4'h0, 4'h0, 1'b0));
        tbl.push_back(x(beq(5'd4, 5'd2),     1'b1, 4'h0, 4'h0, 1'b0));
        tbl.push_back(x(beq(5'd4, 5'd2),     1'b0, 4'b0001, 4'h0, 1'b0));
        tbl.push_back(x(nop(),               1'b0, 4'h0, 4'h0, 1'b0));
        tbl.push_back(x(nop(),               1'b0, 4'h0, 4'h0, 1'b0));
        // store data one instruction behind a load: WB forward on rt in EX
        tbl.push_back(x(lw(5'd6, 5'd1),      1'b0, 4'h0, 4'h0, 1'b0));
        tbl.push_back(x(nop(),               1'b0, 4'h0, 4'h0, 1'b0));
        tbl.push_back(x(sw(5'd1, 5'd6),      1'b0, 4'h0, 4'h0, 1'b0));
        tbl.push_back(x(nop(),               1'b0, 4'h0, 4'b0100, 1'b0));
        tbl.push_back(x(nop(),               1'b0, 4'h0, 4'h0, 1'b0));
        // $0 destination never matches
        tbl.push_back(x(alu(5'd0, 5'd1, 5'd2), 1'b0, 4'h0, 4'h0, 1'b0));
        tbl.push_back(x(beq(5'd0, 5'd0),     1'b0, 4'h0, 4'h0, 1'b0));
        tbl.push_back(x(beq(5'd0, 5'd0),     1'b0, 4'h0, 4'h0, 1'b0));
        tbl.push_back(x(nop(),               1'b0, 4'h0, 4'h0, 1'b0));
        // mult then mflo: five busy cycles, mflo held until busy falls
        tbl.push_back(x(mdop(1'b0),          1'b0, 4'h0, 4'h0, 1'b0));
        for (int i = 0; i < 5; i++)
            tbl.push_back(x(mflo(5'd3),      1'b1, 4'h0, 4'h0, 1'b1));
        tbl.push_back(x(mflo(5'd3),          1'b0, 4'h0, 4'h0, 1'b0));
        tbl.push_back(x(alu(5'd8, 5'd3, 5'd2), 1'b0, 4'h0, 4'h0, 1'b0));
        tbl.push_back(x(nop(),               1'b0, 4'h0, 4'b0010, 1'b0));
        tbl.push_back(x(nop(),               1'b0, 4'h0, 4'h0, 1'b0));
        tbl.push_back(x(nop(),               1'b0, 4'h0, 4'h0, 1'b0));
        // store data directly behind a load: no stall
        tbl.push_back(x(lw(5'd7, 5'd1),      1'b0, 4'h0, 4'h0, 1'b0));
        tbl.push_back(x(sw(5'd1, 5'd7),      1'b0, 4'h0, 4'h0, 1'b0));

        rst_n = 1'b0;
        drive(nop());
        repeat (2) @(negedge clk);
        #1;
        check_outs("reset", 0, 1'b0, 4'h0, 4'h0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            drive(tbl[i]);
            #1;
            check_outs("vec", i, tbl[i].x_stall, tbl[i].x_fid, tbl[i].x_fex, tbl[i].x_busy);
        end

        // Full divide busy period behind a start, from a clean reset.
        @(negedge clk);
        rst_n = 1'b0;
        drive(nop());
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        drive(mdop(1'b1));
        #1;
        check("div_start.stall", 0, 8'(stall), 8'd0);
        count_busy("div", busy);
        check("div.busy_cycles", 0, 8'(busy), 8'd10);
        @(negedge clk);
        drive(nop());

        // Reset asserted with the divide counter at 7.
        @(negedge clk);
        drive(mdop(1'b1));
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive(mflo(5'd3));
        end
        #1;
        check("div_at7.md_busy", 0, 8'(md_busy), 8'd1);
        check("div_at7.stall",   0, 8'(stall),   8'd1);
        rst_n = 1'b0;
        #1;
        check_outs("abort", 0, 1'b0, 4'h0, 4'h0, 1'b0);
        @(negedge clk);
        drive(nop());
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        drive(mdop(1'b0));
        count_busy("mul_after_reset", busy);
        check("mul_after_reset.busy_cycles", 0, 8'(busy), 8'd5);
        @(negedge clk);
        drive(nop());

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
